// File: rtl/vga_timing_if.sv
// Raster-side bundle between the VGA timing generator and its pixel source / display pins.
interface vga_timing_if #(
  parameter int unsigned RGB_W   = 12,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned FRAME_W = 16
);
  logic               timing_en;
  logic [RGB_W-1:0]   pixel_data;
  logic               data_req;
  logic [CNT_W-1:0]   pixel_x;
  logic [CNT_W-1:0]   pixel_y;
  logic               vga_hs;
  logic               vga_vs;
  logic [RGB_W-1:0]   vga_rgb;
  logic               frame_start;
  logic               line_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  timing_en, pixel_data,
    output data_req, pixel_x, pixel_y, vga_hs, vga_vs, vga_rgb,
           frame_start, line_start, frame_cnt
  );

  modport slave (
    output timing_en, pixel_data,
    input  data_req, pixel_x, pixel_y, vga_hs, vga_vs, vga_rgb,
           frame_start, line_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, early pixel request, blanked registered RGB,
// line/frame strobes and a wrapping frame counter.
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned RGB_W    = 12,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned REQ_LEAD = 1,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic         vga_clk,
  input  logic         sys_rst_n,
  vga_timing_if.master tim_io
);

  // One extra bit so window bounds near the counter limit never overflow.
  typedef logic [CNT_W:0] ext_t;

  localparam ext_t H_LAST  = ext_t'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam ext_t HS_END  = ext_t'(H_SYNC);
  localparam ext_t HA      = ext_t'(H_SYNC + H_BACK);
  localparam ext_t HA_END  = ext_t'(H_SYNC + H_BACK + H_DISP);
  localparam ext_t REQ_BEG = ext_t'(H_SYNC + H_BACK - REQ_LEAD);
  localparam ext_t REQ_END = ext_t'(H_SYNC + H_BACK + H_DISP - REQ_LEAD);
  localparam ext_t V_LAST  = ext_t'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam ext_t VS_END  = ext_t'(V_SYNC);
  localparam ext_t VA      = ext_t'(V_SYNC + V_BACK);
  localparam ext_t VA_END  = ext_t'(V_SYNC + V_BACK + V_DISP);

  logic [CNT_W-1:0]   cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0]   cnt_v_q, cnt_v_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;

  logic en;
  ext_t h_ext, v_ext;
  logic h_last, v_last;
  logic row_act, active, data_req;

  assign en     = tim_io.timing_en;
  assign h_ext  = {1'b0, cnt_h_q};
  assign v_ext  = {1'b0, cnt_v_q};
  assign h_last = (h_ext == H_LAST);
  assign v_last = (v_ext == V_LAST);

  assign row_act  = (v_ext >= VA) && (v_ext < VA_END);
  assign active   = (h_ext >= HA) && (h_ext < HA_END) && row_act;
  assign data_req = en && row_act && (h_ext >= REQ_BEG) && (h_ext < REQ_END);

  always_comb begin
    cnt_h_d     = cnt_h_q;
    cnt_v_d     = cnt_v_q;
    frame_cnt_d = frame_cnt_q;
    if (!en) begin
      // Disabled raster parks at the origin; an aborted frame is not counted.
      cnt_h_d = '0;
      cnt_v_d = '0;
    end else if (h_last) begin
      cnt_h_d = '0;
      if (v_last) begin
        cnt_v_d     = '0;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end else begin
        cnt_v_d = cnt_v_q + 1'b1;
      end
    end else begin
      cnt_h_d = cnt_h_q + 1'b1;
    end
  end

  always_comb begin
    hs_d          = (en && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
    vs_d          = (en && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
    rgb_d         = (en && active) ? tim_io.pixel_data : '0;
    line_start_d  = en && (cnt_h_q == '0);
    frame_start_d = en && (cnt_h_q == '0) && (cnt_v_q == '0);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q       <= '0;
      cnt_v_q       <= '0;
      frame_cnt_q   <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      rgb_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      frame_cnt_q   <= frame_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      rgb_q         <= rgb_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign tim_io.data_req    = data_req;
  assign tim_io.pixel_x     = data_req ? CNT_W'(h_ext - REQ_BEG) : '0;
  assign tim_io.pixel_y     = data_req ? CNT_W'(v_ext - VA) : '0;
  assign tim_io.vga_hs      = hs_q;
  assign tim_io.vga_vs      = vs_q;
  assign tim_io.vga_rgb     = rgb_q;
  assign tim_io.line_start  = line_start_q;
  assign tim_io.frame_start = frame_start_q;
  assign tim_io.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing, a small high-polarity raster with 3-cycle
// request lead and enable abort, and a tiny raster that wraps a 2-bit frame counter.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic sys_rst_n;
  always #5 vga_clk = ~vga_clk;

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_if #(.RGB_W(12), .CNT_W(11), .FRAME_W(16)) if_a ();
  vga_timing_if #(.RGB_W(12), .CNT_W(11), .FRAME_W(16)) if_b ();
  vga_timing_if #(.RGB_W(12), .CNT_W(11), .FRAME_W(2))  if_c ();

  vga_timing_gen u_a (.vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .tim_io(if_a));

  vga_timing_gen #(
    .H_SYNC(8), .H_BACK(6), .H_DISP(16), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(3), .V_DISP(6),  .V_FRONT(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(3)
  ) u_b (.vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .tim_io(if_b));

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
    .FRAME_W(2)
  ) u_c (.vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .tim_io(if_c));

  typedef struct {
    logic       hs;
    logic       vs;
    logic [11:0] rgb;
    logic       ls;
    logic       fs;
  } out_t;

  typedef struct {
    int   h;
    int   v;
    logic req;
    int   px;
    int   py;
  } vec_a_t;

  typedef struct {
    int         edge_n;
    logic [1:0] fc;
    logic       fs;
  } vec_c_t;

  out_t         sb_q[$];
  logic [11:0]  src_q[$];
  vec_a_t       tab_a[10];
  vec_c_t       tab_c[9];

  task automatic check(input string name, input int at, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, at, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int at, input out_t e, input logic hs,
                           input logic vs, input logic [11:0] rgb, input logic ls,
                           input logic fs);
    check({tag, "_hs"},  at, hs,  e.hs);
    check({tag, "_vs"},  at, vs,  e.vs);
    check({tag, "_rgb"}, at, rgb, e.rgb);
    check({tag, "_ls"},  at, ls,  e.ls);
    check({tag, "_fs"},  at, fs,  e.fs);
  endtask

  function automatic logic in_rng(int c, int lo, int hi);
    return (c >= lo) && (c < hi);
  endfunction

  function automatic logic [11:0] col(int x, int y);
    return {4'(x), 4'(y), 4'h5};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   h, v, ti, first_req, req_line;
    logic exp_req, act;
    out_t e;

    tab_a = '{
      '{0,   0,  1'b0, 0,   0},
      '{799, 0,  1'b0, 0,   0},
      '{143, 34, 1'b0, 0,   0},
      '{0,   35, 1'b0, 0,   0},
      '{142, 35, 1'b0, 0,   0},
      '{143, 35, 1'b1, 0,   0},
      '{144, 35, 1'b1, 1,   0},
      '{400, 35, 1'b1, 257, 0},
      '{782, 35, 1'b1, 639, 0},
      '{783, 35, 1'b0, 0,   0}
    };
    tab_c = '{
      '{1,   2'd0, 1'b1},
      '{59,  2'd0, 1'b0},
      '{60,  2'd1, 1'b0},
      '{61,  2'd1, 1'b1},
      '{120, 2'd2, 1'b0},
      '{180, 2'd3, 1'b0},
      '{240, 2'd0, 1'b0},
      '{241, 2'd0, 1'b1},
      '{300, 2'd1, 1'b0}
    };

    sys_rst_n = 1'b0;
    if_a.timing_en = 1'b0;  if_a.pixel_data = 12'h000;
    if_b.timing_en = 1'b0;  if_b.pixel_data = 12'hFFF;
    if_c.timing_en = 1'b0;  if_c.pixel_data = 12'h000;

    repeat (5) @(posedge vga_clk);
    @(negedge vga_clk);
    check("rst_hs",  0, if_a.vga_hs, 1'b1);
    check("rst_vs",  0, if_a.vga_vs, 1'b1);
    check("rst_rgb", 0, if_a.vga_rgb, 12'h000);
    check("rst_fc",  0, if_a.frame_cnt, 16'd0);
    check("rst_req", 0, if_a.data_req, 1'b0);
    check("rst_fs",  0, if_a.frame_start, 1'b0);
    check("rst_ls",  0, if_a.line_start, 1'b0);
    check("rst_b_hs", 0, if_b.vga_hs, 1'b0);

    // Default 640x480 raster up to the end of the first displayed line.
    sys_rst_n = 1'b1;
    if_a.timing_en = 1'b1;
    if_a.pixel_data = 12'hA5A;
    ti = 0; first_req = -1; req_line = 0;
    for (int j = 0; j <= 28800; j++) begin
      if (j > 0) begin
        @(posedge vga_clk);
        @(negedge vga_clk);
        if (sb_q.size() == 0) begin
          check("a_sb_empty", j, 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check_out("a", j, e, if_a.vga_hs, if_a.vga_vs, if_a.vga_rgb,
                    if_a.line_start, if_a.frame_start);
        end
      end
      h = j % 800;
      v = (j / 800) % 525;
      exp_req = in_rng(h, 143, 783) && in_rng(v, 35, 515);
      act     = in_rng(h, 144, 784) && in_rng(v, 35, 515);
      check("a_req", j, if_a.data_req, exp_req);
      if (if_a.data_req === 1'b1 && first_req < 0) first_req = j;
      if (if_a.data_req === 1'b1 && v == 35) req_line++;
      if (ti < 10 && (tab_a[ti].v * 800 + tab_a[ti].h) == j) begin
        check("a_tab_req", j, if_a.data_req, tab_a[ti].req);
        check("a_tab_px",  j, if_a.pixel_x, tab_a[ti].px);
        check("a_tab_py",  j, if_a.pixel_y, tab_a[ti].py);
        ti++;
      end
      e.hs  = (h < 96) ? 1'b0 : 1'b1;
      e.vs  = (v < 2)  ? 1'b0 : 1'b1;
      e.rgb = act ? 12'hA5A : 12'h000;
      e.ls  = (h == 0);
      e.fs  = (h == 0) && (v == 0);
      sb_q.push_back(e);
    end
    check("a_first_req_pos", 0, first_req, 35 * 800 + 143);
    check("a_reqs_per_line", 0, req_line, 640);
    check("a_table_applied", 0, ti, 10);
    check("a_fc", 0, if_a.frame_cnt, 16'd0);
    sb_q.delete();
    if_a.timing_en = 1'b0;

    // Small raster, high sync polarity, 3-cycle request lead with a delayed echoing source.
    if_b.timing_en = 1'b1;
    for (int j = 0; j <= 1161; j++) begin
      if (j > 0) begin
        @(posedge vga_clk);
        @(negedge vga_clk);
        if (sb_q.size() == 0) begin
          check("b_sb_empty", j, 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check_out("b", j, e, if_b.vga_hs, if_b.vga_vs, if_b.vga_rgb,
                    if_b.line_start, if_b.frame_start);
        end
      end
      h = j % 34;
      v = (j / 34) % 13;
      exp_req = in_rng(h, 11, 27) && in_rng(v, 5, 11);
      act     = in_rng(h, 14, 30) && in_rng(v, 5, 11);
      check("b_req", j, if_b.data_req, exp_req);
      check("b_px",  j, if_b.pixel_x, exp_req ? h - 11 : 0);
      check("b_py",  j, if_b.pixel_y, exp_req ? v - 5 : 0);
      check("b_fc",  j, if_b.frame_cnt, j / 442);
      src_q.push_back(if_b.data_req ? col(if_b.pixel_x, if_b.pixel_y) : 12'hFFF);
      if (src_q.size() > 3) if_b.pixel_data = src_q.pop_front();
      e.hs  = (h < 8) ? 1'b1 : 1'b0;
      e.vs  = (v < 2) ? 1'b1 : 1'b0;
      e.rgb = act ? col(h - 14, v - 5) : 12'h000;
      e.ls  = (h == 0);
      e.fs  = (h == 0) && (v == 0);
      sb_q.push_back(e);
    end
    sb_q.delete();
    src_q.delete();

    // Abort mid-frame (row 8), hold disabled for 10 clocks, then restart.
    if_b.timing_en  = 1'b0;
    if_b.pixel_data = 12'hFFF;
    for (int k = 1; k <= 10; k++) begin
      @(posedge vga_clk);
      @(negedge vga_clk);
      check("ab_hs",  k, if_b.vga_hs, 1'b0);
      check("ab_vs",  k, if_b.vga_vs, 1'b0);
      check("ab_rgb", k, if_b.vga_rgb, 12'h000);
      check("ab_ls",  k, if_b.line_start, 1'b0);
      check("ab_fs",  k, if_b.frame_start, 1'b0);
      check("ab_req", k, if_b.data_req, 1'b0);
      check("ab_px",  k, if_b.pixel_x, 0);
      check("ab_fc",  k, if_b.frame_cnt, 16'd2);
    end
    if_b.timing_en = 1'b1;
    @(posedge vga_clk);
    @(negedge vga_clk);
    check("re_fs", 1, if_b.frame_start, 1'b1);
    check("re_ls", 1, if_b.line_start, 1'b1);
    check("re_hs", 1, if_b.vga_hs, 1'b1);
    check("re_vs", 1, if_b.vga_vs, 1'b1);
    check("re_fc", 1, if_b.frame_cnt, 16'd2);
    @(posedge vga_clk);
    @(negedge vga_clk);
    check("re_fs_pulse", 2, if_b.frame_start, 1'b0);
    if_b.timing_en = 1'b0;

    // Tiny raster (60 clocks per frame) wrapping a 2-bit frame counter.
    if_c.timing_en = 1'b1;
    ti = 0;
    for (int j = 1; j <= 300; j++) begin
      @(posedge vga_clk);
      @(negedge vga_clk);
      if (ti < 9 && tab_c[ti].edge_n == j) begin
        check("c_fc", j, if_c.frame_cnt, tab_c[ti].fc);
        check("c_fs", j, if_c.frame_start, tab_c[ti].fs);
        ti++;
      end
    end
    check("c_table_applied", 0, ti, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
